// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked add/sub with valid/ready backpressure and carry/overflow/zero flags; define PIPELINED_ADDER_SAT_EN to saturate on signed overflow
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = WIDTH / STAGES;
  logic              stall;
  logic [STAGES-1:0] v_q, v_d, c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [WIDTH-1:0]  sn [STAGES];
  logic [CW:0]       cs [STAGES];
  logic [WIDTH-1:0]  res, out_q, out_d;
  logic              ovf;
  logic              out_valid_q, out_valid_d, cout_q, cout_d, overflow_q, overflow_d, zero_q, zero_d;

  always_comb begin
    stall = out_valid_q && !out_ready;
    in_ready = !reset && !stall;
    v_d[0] = in_valid;
    a_d[0] = in0;
    b_d[0] = sub ? ~in1 : in1;
    s_d[0] = '0;
    c_d[0] = sub | cin;
    for (int k = 0; k < STAGES; k++) begin
      cs[k] = {1'b0, a_q[k][k*CW +: CW]} + {1'b0, b_q[k][k*CW +: CW]} + {{CW{1'b0}}, c_q[k]};
      sn[k] = s_q[k];
      sn[k][k*CW +: CW] = cs[k][CW-1:0];
    end
    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = v_q[k-1];
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      s_d[k] = sn[k-1];
      c_d[k] = cs[k-1][CW];
    end
    ovf = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) && (sn[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
`ifdef PIPELINED_ADDER_SAT_EN
    res = !ovf ? sn[STAGES-1] : a_q[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    res = sn[STAGES-1];
`endif
    out_valid_d = v_q[STAGES-1];
    out_d = out_valid_d ? res : out_q;
    cout_d = out_valid_d ? cs[STAGES-1][CW] : cout_q;
    overflow_d = out_valid_d ? ovf : overflow_q;
    zero_d = out_valid_d ? (res == '0) : zero_q;
    out_valid = out_valid_q;
    out = out_q;
    cout = cout_q;
    overflow = overflow_q;
    zero = zero_q;
  end

  always_ff @(posedge clk)
    if (reset) begin
      v_q <= '0;
      out_valid_q <= 1'b0;
      out_q <= '0;
      cout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      v_q <= v_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      c_q <= c_d;
      out_valid_q <= out_valid_d;
      out_q <= out_d;
      cout_q <= cout_d;
      overflow_q <= overflow_d;
      zero_q <= zero_d;
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed checks of pipelined_adder against a behavioural arithmetic model
module tb_pipelined_adder;
  localparam int W = 32;
  localparam int S = 4;
  typedef struct packed {
    logic [W-1:0] o;
    logic         c;
    logic         v;
    logic         z;
  } res_t;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in0 = '0;
  logic [W-1:0] in1 = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         cout;
  logic         overflow;
  logic         zero;
  int           errors = 0;
  int           checks = 0;
  int           n_out = 0;
  res_t         q[$];
  logic         prev_stall = 1'b0;
  logic [W+2:0] prev = '0;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .cout(cout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic s);
    res_t r;
    logic [W-1:0] eb;
    logic [63:0] full;
    longint ec, ts;
    eb = s ? ~b : b;
    ec = s ? 1 : longint'(ci);
    full = {32'b0, a} + {32'b0, eb} + 64'(ec);
    ts = longint'($signed(a)) + longint'($signed(eb)) + ec;
    r.o = full[W-1:0];
    r.c = full[W];
    r.v = (ts > 64'sd2147483647) || (ts < -64'sd2147483648);
`ifdef PIPELINED_ADDER_SAT_EN
    if (ts > 64'sd2147483647) r.o = 32'h7FFFFFFF;
    else if (ts < -64'sd2147483648) r.o = 32'h80000000;
`endif
    r.z = (r.o == 0);
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (reset) begin
      q.delete();
      prev_stall = 1'b0;
      chk("in_ready_in_reset", 64'(in_ready), 64'd0);
    end else begin
      chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (prev_stall) chk("stall_hold", 64'({out_valid, cout, overflow, zero, out}), 64'({1'b1, prev}));
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("out", 64'(out), 64'(e.o));
          chk("cout", 64'(cout), 64'(e.c));
          chk("overflow", 64'(overflow), 64'(e.v));
          chk("zero", 64'(zero), 64'(e.z));
        end
      end
      if (in_valid && in_ready) q.push_back(model(in0, in1, cin, sub));
      prev_stall = out_valid && !out_ready;
      prev = {cout, overflow, zero, out};
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    int t = 0;
    in0 = a;
    in1 = b;
    cin = c;
    sub = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s,
                          input logic [W-1:0] eo, input logic ec, input logic ev, input logic ez);
    int lat = -1;
    send(a, b, c, s);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk({name, "_latency"}, 64'(lat), 64'(S));
    chk({name, "_out"}, 64'(out), 64'(eo));
    chk({name, "_cout"}, 64'(cout), 64'(ec));
    chk({name, "_ovf"}, 64'(overflow), 64'(ev));
    chk({name, "_zero"}, 64'(zero), 64'(ez));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, nr, seen;
    logic took;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_flags", 64'({out, cout, overflow, zero}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    directed("carry_boundary", 32'h000000FF, 32'h1, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
    directed("wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
`ifdef PIPELINED_ADDER_SAT_EN
    directed("signed_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
`else
    directed("signed_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
`endif
    directed("sub_5_8", 32'd5, 32'd8, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
    directed("sub_8_5", 32'd8, 32'd5, 1'b1, 1'b1, 32'd3, 1'b1, 1'b0, 1'b0);
    base = n_out;
    nr = 0;
    fork
      begin
        for (int i = 1; i <= 10; i++) send(W'(i), W'(100 * i), 1'b0, 1'b0);
      end
      begin
        for (int c = 0; c < 20; c++) begin
          out_ready = !(c >= 6 && c < 9);
          @(posedge clk);
          #1;
        end
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (!in_ready) nr++;
        end
      end
    join
    out_ready = 1'b1;
    chk("bp_results", 64'(n_out - base), 64'd10);
    chk("bp_stall_cycles", 64'(nr), 64'd3);
    for (int i = 1; i <= 3; i++) send(W'(i), W'(7), 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_flags", 64'({out, cout, overflow, zero}), 64'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midreset_no_stale", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    directed("after_reset", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0);
    in0 = rnd();
    in1 = rnd();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took || !in_valid) begin
        in0 = rnd();
        in1 = rnd();
        cin = 1'($urandom);
        sub = 1'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 9) < 7);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
